// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    localparam logic REQ_UC  = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for two requesters; on a tie the requester not granted last wins.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic req_0,
    input  logic req_1,
    input  logic last_gnt,
    output logic win
);

    // A last_gnt tied to REQ_DBG turns this into fixed priority for requester 0.
    always_comb begin
        win = REQ_UC;
        if (req_0 && req_1) begin
            win = ~last_gnt;
        end else if (req_1) begin
            win = REQ_DBG;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port single-RAM access arbiter: one transaction per 4 cycles, ack on the 3rd cycle.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
//   state  | meaning
//   IDLE   | waiting for a request, winner captured on exit
//   ACCESS | address/data on the RAM, write strobe for writes
//   WAIT   | RAM read data valid, captured into rdata at the end
//   ACK    | ack pulse to the granted requester
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              ack_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              ack_1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt_id,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    state_t state, state_nxt;
    logic   take;
    logic   load_rd;
    logic   win;
    logic   last_gnt;
    logic   we_q;

    ram_arb_pick u_pick (
        .req_0    (req_0),
        .req_1    (req_1),
        .last_gnt (last_gnt),
        .win      (win)
    );

`ifdef RAM_ARB_RR_EN
    logic last_q;

    // Reset value makes requester 0 the first tie winner.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= REQ_DBG;
        end else if (take) begin
            last_q <= win;
        end
    end

    assign last_gnt = last_q;
`else
    assign last_gnt = REQ_DBG;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        load_rd   = 1'b0;
        busy      = 1'b1;
        ram_wren  = 1'b0;
        ack_0     = 1'b0;
        ack_1     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req_0 || req_1) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_wren  = we_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                load_rd   = ~we_q;
                state_nxt = ACK;
            end
            ACK: begin
                ack_0     = (gnt_id == REQ_UC);
                ack_1     = (gnt_id == REQ_DBG);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM-side address/data come only from these registers, never from requester inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_id      <= REQ_UC;
            we_q        <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            rdata       <= '0;
        end else begin
            if (take) begin
                gnt_id      <= win;
                we_q        <= win ? we_1 : we_0;
                ram_address <= win ? addr_1 : addr_0;
                ram_data    <= win ? wdata_1 : wdata_0;
            end
            if (load_rd) begin
                rdata <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios then randomized transactions.
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_0 = 1'b0, we_0 = 1'b0, req_1 = 1'b0, we_1 = 1'b0;
    logic [4:0]  addr_0 = '0, addr_1 = '0;
    logic [15:0] wdata_0 = '0, wdata_1 = '0;
    logic        ack_0, ack_1, busy, gnt_id, ram_wren;
    logic [15:0] rdata, ram_data;
    logic [15:0] ram_q = '0;
    logic [4:0]  ram_address;

    int errors = 0;
    int checks = 0;

    // Environment RAM: synchronous, read data one clock after the address edge.
    logic [15:0] mem [32];
    // Reference model state.
    logic [15:0] ref_mem [32];
    logic [15:0] rdata_m = '0;
    bit          last_m = 1'b1;

    ram_arbiter dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .ack_0(ack_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .ack_1(ack_1),
        .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick_model(input bit r0, input bit r1);
`ifdef RAM_ARB_RR_EN
        if (r0 && r1) return !last_m;
`endif
        return r0 ? 1'b0 : 1'b1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // mode: 0 drop requests in ACCESS, 1 drop in WAIT, 2 keep holding.
    // poke: raise both requests while busy and drop them before IDLE.
    task automatic txn(input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input int mode, input bit poke, output logic gnt_obs);
        bit          win, we_e;
        logic [4:0]  a_e;
        logic [15:0] d_e;
        req_0 = r0; req_1 = r1; we_0 = w0; we_1 = w1;
        addr_0 = a0; addr_1 = a1; wdata_0 = d0; wdata_1 = d1;
        step();
        win  = pick_model(r0, r1);
        last_m = win;
        we_e = win ? w1 : w0;
        a_e  = win ? a1 : a0;
        d_e  = win ? d1 : d0;
        gnt_obs = gnt_id;
        check("gnt_id", gnt_id, win);
        check("busy_access", busy, 1);
        check("wren_access", ram_wren, we_e);
        check("ram_address", ram_address, a_e);
        if (we_e) check("ram_data", ram_data, d_e);
        check("acks_access", {ack_0, ack_1}, 0);
        if (mode == 0) begin req_0 = 1'b0; req_1 = 1'b0; end
        step();
        check("wren_wait", ram_wren, 0);
        check("acks_wait", {ack_0, ack_1}, 0);
        if (mode == 1) begin req_0 = 1'b0; req_1 = 1'b0; end
        if (poke) begin req_0 = 1'b1; req_1 = 1'b1; end
        step();
        if (we_e) ref_mem[a_e] = d_e;
        else rdata_m = ref_mem[a_e];
        check("ack_0", ack_0, win == 1'b0);
        check("ack_1", ack_1, win == 1'b1);
        check("rdata_ack", rdata, rdata_m);
        check("wren_ack", ram_wren, 0);
        if (poke) begin req_0 = 1'b0; req_1 = 1'b0; end
        step();
        check("busy_idle", busy, 0);
        check("acks_idle", {ack_0, ack_1}, 0);
        check("wren_idle", ram_wren, 0);
        check("rdata_idle", rdata, rdata_m);
    endtask

    initial begin
        logic       g;
        logic [3:0] spec_seq;
`ifdef RAM_ARB_RR_EN
        spec_seq = 4'b1010;
`else
        spec_seq = 4'b0000;
`endif
        for (int i = 0; i < 32; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[5] = 16'hBEEF;
        ref_mem[5] = 16'hBEEF;

        #12;
        check("rst_busy", busy, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_acks", {ack_0, ack_1}, 0);
        check("rst_gnt", gnt_id, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", ram_address, 0);
        check("rst_data", ram_data, 0);
        step();
        reset = 1'b1;
        step();

        // Single read of RAM[5] by the control unit.
        txn(1, 0, 0, 0, 5'd5, 5'd0, 16'h0, 16'h0, 0, 0, g);
        check("single_read_rdata", rdata, 16'hBEEF);

        // Debug port writes then reads address 31.
        txn(0, 1, 0, 1, 5'd0, 5'd31, 16'h0, 16'h1234, 0, 0, g);
        check("write_keeps_rdata", rdata, 16'hBEEF);
        txn(0, 1, 0, 0, 5'd0, 5'd31, 16'h0, 16'h0, 0, 0, g);
        check("read_back", rdata, 16'h1234);

        // Both requesters held for four rounds.
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 0, 1, 5'd5, 5'd9, 16'h0, 16'h5A5A + 16'(i), (i < 3) ? 2 : 0, 0, g);
            check("simul_grant", g, spec_seq[i]);
        end

        // Request dropped during WAIT.
        txn(1, 0, 0, 0, 5'd31, 5'd0, 16'h0, 16'h0, 1, 0, g);
        step();
        check("idle_after_drop", busy, 0);

        // Back-to-back with req_0 held.
        for (int i = 0; i < 3; i++)
            txn(1, 0, 1, 0, 5'(10 + i), 5'd0, 16'(16'hA000 + i), 16'h0, (i < 2) ? 2 : 0, 0, g);

        // Reset during ACCESS of a write.
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 5'd7; wdata_1 = 16'hDEAD;
        step();
        check("pre_reset_wren", ram_wren, 1);
        reset = 1'b0;
        #1;
        check("abort_wren", ram_wren, 0);
        check("abort_busy", busy, 0);
        check("abort_rdata", rdata, 0);
        check("abort_addr", ram_address, 0);
        step();
        check("abort_acks", {ack_0, ack_1}, 0);
        req_1 = 1'b0; we_1 = 1'b0;
        reset = 1'b1;
        rdata_m = '0;
        last_m = 1'b1;
        step();
        check("post_reset_idle", busy, 0);
        txn(1, 0, 0, 0, 5'd7, 5'd0, 16'h0, 16'h0, 0, 0, g);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            bit r0, r1;
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r1 = 1'b1;
            txn(r0, r1, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                16'($urandom), 16'($urandom), 0, 1'($urandom), g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
